// File: rtl/vga_fb_arbiter.sv
// Video RAM arbiter: a fixed display-read slot on phase 0 of each active pixel
// period, with every other clock granted to the CPU-side req/ack port.
module vga_fb_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int SCALE  = 1,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixpulse,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hblank,
  input  logic              vblank,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] pix_data
);

  localparam logic [1:0] PH_DISP = 2'd0;
  localparam logic [1:0] PH_LBUF = 2'd1;
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

  logic [1:0]        phase;
  logic              disp_slot;
  logic              grant;
  logic              in_range;
  logic              fetched;
  logic              rd_pend;
  logic              rd_ok;
  logic [DATA_W-1:0] line_buf;
  logic [ADDR_W-1:0] disp_addr;

  assign disp_addr = ADDR_W'(vcount >> SCALE) * ADDR_W'(FB_W) + ADDR_W'(hcount >> SCALE);

  // Outputs are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    disp_slot = rst_n && (phase == PH_DISP) && !hblank && !vblank;
    grant     = rst_n && cpu_req && !disp_slot;
    in_range  = {1'b0, cpu_addr} < FB_SIZE;
    cpu_ack   = grant;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (grant && in_range) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      fetched    <= 1'b0;
      line_buf   <= '0;
      pix_data   <= '0;
      rd_pend    <= 1'b0;
      rd_ok      <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      phase <= pixpulse ? '0 : phase + 2'd1;
      if (phase == PH_DISP) fetched <= disp_slot;
      if (phase == PH_LBUF && fetched) line_buf <= mem_rdata;
      if (pixpulse) pix_data <= fetched ? line_buf : '0;
      // Read return: RAM data lands on the cycle after the ack, result visible one later.
      rd_pend    <= grant && !cpu_we;
      rd_ok      <= in_range;
      cpu_rvalid <= rd_pend;
      if (rd_pend) cpu_rdata <= rd_ok ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: driver pushes per-cycle expectations from a
// slot/RAM reference model; a negedge monitor pops and compares.
module tb_vga_fb_arbiter;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int SCALE  = 1;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int unsigned FB_SIZE = FB_W * FB_H;

  typedef struct { int unsigned cyc; bit ack; bit en; bit we; bit idle; int unsigned addr; int unsigned wdata; } chk_t;
  typedef struct { int unsigned due; int unsigned val; } exp_t;
  typedef struct { bit we; int unsigned addr; int unsigned wdata; } op_t;
  typedef struct { int unsigned h; int unsigned v; bit hb; bit vb; } vid_t;

  logic              clk;
  logic              rst_n;
  logic              pixpulse;
  logic [9:0]        hcount, vcount;
  logic              hblank, vblank;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] pix_data;

  vga_fb_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse),
    .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .pix_data(pix_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] fill(input int unsigned i);
    int unsigned x;
    x = i * 32'd2654435761;
    return 12'(x >> 13);
  endfunction

  // Environment RAM: synchronous single port, read data valid the next cycle.
  logic [11:0] env_ram [0:131071];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 131072; i++) env_ram[i] <= fill(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) env_ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_ram[mem_addr];
    end
  end

  // Reference contents: initial fill plus every in-range write the model granted.
  int unsigned ref_ram [int unsigned];
  function automatic int unsigned refget(input int unsigned a);
    if (ref_ram.exists(a)) return ref_ram[a];
    return 32'(fill(a));
  endfunction

  chk_t chk_q[$];
  exp_t rd_q[$];
  exp_t pix_q[$];
  op_t  ops[$];
  vid_t vid_script[$];

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned since_rel = 0;
  int unsigned ph = 0;
  int unsigned rst_hold = 0;
  int unsigned vh = 0, vv = 0;
  bit vhb = 1'b0, vvb = 1'b0;
  bit run = 1'b0;
  bit rand_ops = 1'b0;
  bit cur_valid = 1'b0;
  bit rd_acked = 1'b0;
  op_t cur;
  int unsigned rd_hold = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic next_video();
    vid_t s;
    if (vid_script.size() > 0) begin
      s = vid_script.pop_front();
      vh = s.h; vv = s.v; vhb = s.hb; vvb = s.vb;
      return;
    end
    if ($urandom_range(0, 7) == 0) begin
      vh = $urandom_range(0, 799);
      vv = $urandom_range(0, 524);
    end else begin
      vh++;
      if (vh == 800) begin vh = 0; vv = (vv + 1) % 525; end
    end
    vhb = (vh >= 640);
    vvb = (vv >= 480);
  endtask

  function automatic op_t rand_op();
    op_t o;
    int unsigned r;
    r = $urandom_range(0, 7);
    o.we = $urandom_range(0, 1) == 1;
    o.wdata = $urandom & 32'hFFF;
    case (r)
      0:       o.addr = FB_SIZE - 1;
      1:       o.addr = FB_SIZE;
      2:       o.addr = $urandom_range(FB_SIZE, 131071);
      3, 4:    o.addr = $urandom_range(0, 15) * 1000;
      default: o.addr = $urandom_range(0, FB_SIZE - 1);
    endcase
    return o;
  endfunction

  // One clock: drive inputs just after the edge, then record what the model expects.
  task automatic step();
    bit was_rst, disp, ack, inr;
    int unsigned a;
    chk_t e;
    @(posedge clk); #1;
    cyc++;
    was_rst = !rst_n;
    if (rst_hold > 0) begin rst_n = 1'b0; rst_hold--; end
    else rst_n = 1'b1;
    if (!rst_n) begin rd_q.delete(); pix_q.delete(); end
    if (rst_n) begin
      since_rel = was_rst ? 0 : since_rel + 1;
      ph = since_rel % 4;
      if (ph == 0) next_video();
    end
    pixpulse = rst_n && (ph == 3);
    hcount = 10'(vh); vcount = 10'(vv); hblank = vhb; vblank = vvb;
    if (!cur_valid && ops.size() > 0) begin cur = ops.pop_front(); cur_valid = 1'b1; end
    if (!cur_valid && rand_ops && $urandom_range(0, 2) == 0) begin cur = rand_op(); cur_valid = 1'b1; end
    cpu_req = cur_valid; cpu_we = cur.we;
    cpu_addr = 17'(cur.addr); cpu_wdata = 12'(cur.wdata);

    disp = rst_n && (ph == 0) && !vhb && !vvb;
    ack  = rst_n && cur_valid && !disp;
    inr  = cur.addr < FB_SIZE;
    a    = ((vv >> SCALE) * FB_W + (vh >> SCALE)) % 131072;
    e.cyc = cyc; e.ack = ack;
    e.en = disp || (ack && inr);
    e.we = ack && inr && cur.we;
    e.idle = !disp && !ack;
    e.addr = disp ? a : cur.addr;
    e.wdata = cur.wdata;
    chk_q.push_back(e);
    if (rst_n && since_rel == 0) pix_q.push_back('{cyc + 2, 0});
    if (rst_n && ph == 0) pix_q.push_back('{cyc + 6, disp ? refget(a) : 0});
    rd_acked = ack && !cur.we;
    if (ack) begin
      if (!cur.we) rd_q.push_back('{cyc + 2, inr ? refget(cur.addr) : 0});
      else if (inr) ref_ram[cur.addr] = cur.wdata;
      cur_valid = 1'b0;
    end
  endtask

  task automatic align_ph3();
    for (int i = 0; i < 64; i++) begin
      if (rst_n && ph == 3 && !cur_valid && ops.size() == 0) break;
      step();
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk_t e;
      exp_t r;
      if (chk_q.size() == 0 || chk_q[0].cyc != cyc) begin
        chk("sched", chk_q.size() > 0 ? chk_q[0].cyc : 0, cyc);
      end else begin
        e = chk_q.pop_front();
        chk("ack", 32'(cpu_ack), 32'(e.ack));
        chk("mem_en", 32'(mem_en), 32'(e.en));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.en) chk("mem_addr", 32'(mem_addr), e.addr);
        if (e.we) chk("mem_wdata", 32'(mem_wdata), e.wdata);
        if (e.idle) begin
          chk("idle_addr", 32'(mem_addr), 0);
          chk("idle_wdata", 32'(mem_wdata), 0);
        end
      end
      if (!rst_n) rd_hold = 0;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r = rd_q.pop_front();
        chk("rvalid", 32'(cpu_rvalid), 1);
        chk("rdata", 32'(cpu_rdata), r.val);
        rd_hold = r.val;
      end else begin
        chk("rvalid_idle", 32'(cpu_rvalid), 0);
        chk("rdata_hold", 32'(cpu_rdata), rd_hold);
      end
      if (!rst_n) chk("pix_rst", 32'(pix_data), 0);
      else if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        r = pix_q.pop_front();
        chk("pix", 32'(pix_data), r.val);
      end
    end
  end

  initial begin
    rst_n = 1'b0; pixpulse = 1'b0; hcount = '0; vcount = '0; hblank = 1'b0; vblank = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cur = '{0, 0, 0};

    // Reset with a request held, then a display fetch of the written pixel.
    ops.push_back('{1, 965, 32'hABC});
    vid_script.push_back('{650, 7, 1, 0});
    vid_script.push_back('{10, 7, 0, 0});
    vid_script.push_back('{11, 7, 0, 0});
    vid_script.push_back('{12, 7, 0, 0});
    rst_hold = 6;
    step();
    run = 1'b1;
    repeat (25) step();

    // CPU write arriving on an active display slot.
    align_ph3();
    vid_script.push_back('{20, 9, 0, 0});
    ops.push_back('{1, 100, 32'h5A5});
    repeat (8) step();

    // Blanking: eight back-to-back grants.
    align_ph3();
    vid_script.push_back('{700, 100, 1, 0});
    vid_script.push_back('{701, 100, 1, 0});
    for (int i = 0; i < 8; i++) ops.push_back('{1, 200 + i, 32'h100 + i});
    repeat (10) step();

    // Last valid address and first out-of-range address.
    ops.push_back('{1, FB_SIZE - 1, 32'h123});
    ops.push_back('{0, FB_SIZE - 1, 0});
    ops.push_back('{1, FB_SIZE, 32'h777});
    ops.push_back('{0, FB_SIZE, 0});
    repeat (16) step();

    rand_ops = 1'b1;
    repeat (4000) step();
    rand_ops = 1'b0;
    repeat (8) step();

    // Reset asserted the cycle after a read grant.
    align_ph3();
    vid_script.push_back('{710, 100, 1, 0});
    ops.push_back('{0, 965, 0});
    for (int i = 0; i < 8 && !rd_acked; i++) step();
    chk("rd_grant_seen", 32'(rd_acked), 1);
    rst_hold = 3;
    repeat (12) step();

    @(negedge clk); #1;
    run = 1'b0;
    chk("rd_drain", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
